// File: rtl/bram_sector_sync.sv
// Save-slot backup RAM sync: moves one slot's sectors between cart BRAM and the SD image,
// one sector per HPS handshake, with autoload on ROM download end and OSD-gated autosave.
//
// state | meaning
// IDLE  | waiting for a load, save, autoload or autosave event
// REQ   | sd_rd or sd_wr held, waiting for an sd_ack rise or timeout
// XFER  | HPS moving one sector, waiting for the sd_ack fall
// FIN   | last sector moved; done pulses as IDLE is entered
module bram_sector_sync #(
  parameter int          SECT_W   = 7,
  parameter int          SLOT_W   = 2,
  parameter logic [31:0] BASE_LBA = 32'd0,
  parameter int          TIMEOUT  = 1 << 24
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              downloading,
  input  logic              img_nonempty,
  input  logic              auto_en,
  input  logic              osd_open,
  input  logic              bram_change,
  input  logic [SLOT_W-1:0] slot,
  input  logic [SECT_W-1:0] sect_count,
  input  logic              sd_ack,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  output logic              loading,
  output logic              busy,
  output logic              pending,
  output logic              done,
  output logic              err
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_FIN} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_load_d, r_save_d, r_ack_d, r_dl_d;
  logic [SLOT_W-1:0] r_slot, w_slot_nxt;
  logic [SECT_W-1:0] r_last, w_last_nxt;
  logic [SECT_W-1:0] r_sect, w_sect_nxt;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic              r_rd, w_rd_nxt;
  logic              r_wr, w_wr_nxt;
  logic              r_loading, w_loading_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic              r_pend;
  logic [31:0]       r_lba, w_lba_nxt;
  logic              w_start_save;

  logic w_load_rise, w_save_rise, w_ack_rise, w_ack_fall, w_dl_fall;
  logic w_load_ev, w_save_ev;

  assign w_load_rise = load_req & ~r_load_d;
  assign w_save_rise = save_req & ~r_save_d;
  assign w_ack_rise  = sd_ack & ~r_ack_d;
  assign w_ack_fall  = ~sd_ack & r_ack_d;
  assign w_dl_fall   = ~downloading & r_dl_d;

  // A load event shadows a simultaneous save event; pending survives for a later save.
  assign w_load_ev = w_load_rise | (w_dl_fall & img_nonempty);
  assign w_save_ev = w_save_rise | (r_pend & osd_open & auto_en);

  always_comb begin
    w_state_nxt   = r_state;
    w_slot_nxt    = r_slot;
    w_last_nxt    = r_last;
    w_sect_nxt    = r_sect;
    w_tmo_nxt     = r_tmo;
    w_rd_nxt      = r_rd;
    w_wr_nxt      = r_wr;
    w_loading_nxt = r_loading;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_start_save  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable && (w_load_ev || w_save_ev)) begin
          w_slot_nxt    = slot;
          w_last_nxt    = sect_count - 1'b1;
          w_sect_nxt    = '0;
          w_tmo_nxt     = '0;
          w_loading_nxt = w_load_ev;
          w_rd_nxt      = w_load_ev;
          w_wr_nxt      = ~w_load_ev;
          w_start_save  = ~w_load_ev;
          w_state_nxt   = S_REQ;
        end
      end
      S_REQ: begin
        if (w_ack_rise) begin
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
          w_state_nxt = S_XFER;
        end else if (r_tmo == TMO_LAST) begin
          w_rd_nxt      = 1'b0;
          w_wr_nxt      = 1'b0;
          w_loading_nxt = 1'b0;
          w_err_nxt     = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      S_XFER: begin
        if (w_ack_fall) begin
          if (r_sect == r_last) begin
            w_state_nxt = S_FIN;
          end else begin
            w_sect_nxt  = r_sect + 1'b1;
            w_tmo_nxt   = '0;
            w_rd_nxt    = r_loading;
            w_wr_nxt    = ~r_loading;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_FIN: begin
        w_loading_nxt = 1'b0;
        w_done_nxt    = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_lba_nxt = BASE_LBA + (32'(w_slot_nxt) << SECT_W) + 32'(w_sect_nxt);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_load_d  <= 1'b0;
      r_save_d  <= 1'b0;
      r_ack_d   <= 1'b0;
      r_dl_d    <= 1'b0;
      r_slot    <= '0;
      r_last    <= '0;
      r_sect    <= '0;
      r_tmo     <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_loading <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_pend    <= 1'b0;
      r_lba     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_load_d  <= load_req;
      r_save_d  <= save_req;
      r_ack_d   <= sd_ack;
      r_dl_d    <= downloading;
      r_slot    <= w_slot_nxt;
      r_last    <= w_last_nxt;
      r_sect    <= w_sect_nxt;
      r_tmo     <= w_tmo_nxt;
      r_rd      <= w_rd_nxt;
      r_wr      <= w_wr_nxt;
      r_loading <= w_loading_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_lba     <= w_lba_nxt;
      if (bram_change && !osd_open) r_pend <= 1'b1;
      else if (w_start_save)        r_pend <= 1'b0;
    end
  end

  assign sd_lba  = r_lba;
  assign sd_rd   = r_rd;
  assign sd_wr   = r_wr;
  assign loading = r_loading;
  assign busy    = (r_state != S_IDLE);
  assign pending = r_pend;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: doc/bram_sector_sync.md
BRAM_SECTOR_SYNC -- requirements
Module: bram_sector_sync

Interface
REQ-001 Parameter SECT_W, default 7, log2 of the maximum sectors per slot (128 sectors of 512 bytes).
REQ-002 Parameter SLOT_W, default 2, log2 of the save-slot count (4 slots).
REQ-003 Parameter BASE_LBA, default 0, 32-bit LBA of slot 0, sector 0.
REQ-004 Parameter TIMEOUT, default 2^24, maximum cycles to wait for sd_ack rise before abort.
REQ-005 Ports, with clk_sys and reset_n first (one clock; reset asynchronous, active-low):
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  save file mounted and writable; requests are ignored when 0
- load_req  in  1  level input; rising edge requests a load
- save_req  in  1  level input; rising edge requests a save
- downloading  in  1  ROM download active; falling edge triggers an autoload
- img_nonempty  in  1  mounted image size is nonzero
- auto_en  in  1  autosave enable
- osd_open  in  1  OSD visible
- bram_change  in  1  cart backup RAM was written
- slot  in  SLOT_W  slot selection, sampled at job start
- sect_count  in  SECT_W  sectors to transfer; 0 means 2^SECT_W; sampled at job start
- sd_ack  in  1  HPS acknowledge, high for the duration of one sector
- sd_lba  out  32  sector address
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- loading  out  1  load in progress; holds the core in reset
- busy  out  1  any job active
- pending  out  1  unsaved backup RAM changes exist
- done  out  1  one-cycle pulse when a job completes
- err  out  1  one-cycle pulse when a job aborts on timeout

Function
REQ-006 The block SHALL detect rising edges of load_req, save_req, and sd_ack, and the falling edge of downloading, using registers clocked by clk_sys.
REQ-007 The FSM SHALL have four states: IDLE, REQ, XFER, FIN.
REQ-008 In IDLE with enable=1, the block SHALL start a job on one of these events:
- rising edge of load_req;
- rising edge of save_req;
- falling edge of downloading while img_nonempty=1 (load);
- autosave, i.e. pending & osd_open & auto_en (save).
REQ-009 When load and save events occur in the same cycle, the block SHALL start the load; the save event SHALL be dropped, and pending SHALL be retained.
REQ-010 On job start, the block SHALL:
- latch slot and sect_count;
- clear the sector counter;
- set loading = (job is a load);
- assert sd_rd for a load or sd_wr for a save;
- enter REQ.
REQ-011 The block SHALL drive sd_lba = BASE_LBA + (slot_latched << SECT_W) + sector, modulo 2^32, stable from REQ entry until XFER exit.
REQ-012 In REQ, on the sd_ack rising edge, the block SHALL clear sd_rd and sd_wr in the same cycle and enter XFER.
REQ-013 In REQ, the timeout counter SHALL increment each cycle.
REQ-014 When the timeout counter reaches TIMEOUT-1 with no ack, the block SHALL: clear sd_rd, sd_wr, and loading; pulse err; return to IDLE.
REQ-015 In XFER, on the sd_ack falling edge:
- if sector = count-1, the block SHALL enter FIN;
- otherwise, it SHALL increment sector, clear the timeout counter, reassert the same request line, and return to REQ.
REQ-016 In FIN (one cycle), the block SHALL clear loading, pulse done, and enter IDLE.
REQ-017 busy SHALL equal (state != IDLE).
REQ-018 pending SHALL be set by bram_change & ~osd_open and cleared when a save job starts; if both happen in the same cycle, set wins.
REQ-019 Edges of load_req, save_req, or downloading that occur while busy=1 SHALL be ignored, not queued.
REQ-020 A rising edge of downloading SHALL not abort an active job.
REQ-021 Deasserting enable mid-job SHALL not abort it.
REQ-022 If sd_ack is already high when a request is asserted, the block SHALL wait for a fresh rising edge.

Reset
REQ-023 While reset_n=0, asynchronously: state=IDLE; sd_lba=0; sd_rd=0; sd_wr=0; loading=0; busy=0; pending=0; done=0; err=0; counters and edge registers zero.
REQ-024 A reset mid-job SHALL drop the request lines immediately; no job SHALL resume after reset release.
REQ-025 Sampling old_downloading=0 at reset SHALL prevent a spurious autoload.

Verification
REQ-026 Defaults, enable=1, slot=0, sect_count=0, rising edge of load_req, HPS model acks each request after 3 cycles for 8 cycles -> 128 reads at LBA 0..127; loading high throughout; a single done pulse; loading low afterward.
REQ-027 slot=2, sect_count=4, rising edge of save_req -> writes at LBA 256..259 only; sd_rd never asserted; done pulse; pending cleared.
REQ-028 bram_change pulse with osd_open=0, auto_en=1, then osd_open=1 -> pending=1, then an autosave job of the programmed size; pending=0 at start.
REQ-029 load_req and save_req rising in the same cycle with pending=1 -> a load job runs; pending remains 1 after done.
REQ-030 TIMEOUT=16, save_req, no sd_ack -> sd_wr high for 16 cycles, then cleared; single err pulse; busy=0; no done pulse.
REQ-031 reset_n asserted during the third sector of a load -> sd_rd and loading fall without a clock edge; after release, IDLE with no requests until a new edge.
